// File: rtl/set_op_sequencer_pkg.sv
// Shared definitions for the set-condition sequencer: op codes, widths,
// FSM state encodings and a small op-code helper.
package set_op_sequencer_pkg;

  localparam int SEQ_WIDTH = 32;
  localparam int SEQ_OPW   = 3;

  // Set-condition op codes; 6 and 7 are reserved and flagged as illegal.
  localparam logic [2:0] OP_SLT  = 3'd0;
  localparam logic [2:0] OP_SEQ  = 3'd1;
  localparam logic [2:0] OP_SNE  = 3'd2;
  localparam logic [2:0] OP_SGT  = 3'd3;
  localparam logic [2:0] OP_SLTE = 3'd4;
  localparam logic [2:0] OP_SGE  = 3'd5;

  // Sequencer states, kept as plain constants so the encoding matches the
  // legacy header bit for bit.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_CAPT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  // Decoded view of a captured response.
  typedef struct packed {
    logic id;
    logic err;
    logic bit_val;
  } set_rsp_t;

  function automatic logic is_legal_op(input logic [2:0] op);
    return (op <= OP_SGE);
  endfunction

endpackage

// File: rtl/set_op_sequencer_if.sv
// Bundle of the two request ports, the adder/subtractor launch port and the
// response port. master = issue logic / adder side, slave = the sequencer.
interface set_op_sequencer_if #(
  parameter int WIDTH = 32,
  parameter int OPW   = 3
);

  logic             req0_valid;
  logic             req0_ready;
  logic [OPW-1:0]   req0_op;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;

  logic             req1_valid;
  logic             req1_ready;
  logic [OPW-1:0]   req1_op;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;

  logic             sub_req;
  logic             sub_mode;
  logic [WIDTH-1:0] sub_a;
  logic [WIDTH-1:0] sub_b;
  logic [WIDTH-1:0] sub_result;
  logic             sub_zf;

  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_err;

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    input  req0_ready,
    output req1_valid, req1_op, req1_a, req1_b,
    input  req1_ready,
    input  sub_req, sub_mode, sub_a, sub_b,
    output sub_result, sub_zf,
    input  rsp_valid, rsp_id, rsp_data, rsp_err,
    output rsp_ready
  );

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    output req0_ready,
    input  req1_valid, req1_op, req1_a, req1_b,
    output req1_ready,
    output sub_req, sub_mode, sub_a, sub_b,
    input  sub_result, sub_zf,
    output rsp_valid, rsp_id, rsp_data, rsp_err,
    input  rsp_ready
  );

endinterface

// File: rtl/set_result_sel.sv
// Combinational set-result selector: the six set cells evaluated from the
// adder sign and zero flags, followed by an op-code mux. Unknown op codes
// give a zero result with err raised.
module set_result_sel
  import set_op_sequencer_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int OPW   = 3
) (
  input  logic [OPW-1:0]   i_op,
  input  logic             i_s,
  input  logic             i_z,
  output logic [WIDTH-1:0] o_result,
  output logic             o_err
);

  logic w_slt;
  logic w_seq;
  logic w_sne;
  logic w_sgt;
  logic w_slte;
  logic w_sge;
  logic w_bit;

  // Set cells; the sign is taken raw, no overflow correction.
  assign w_slt  = i_s;
  assign w_seq  = i_z;
  assign w_sne  = ~i_z;
  assign w_sgt  = ~i_z & ~i_s;
  assign w_slte = i_z | i_s;
  assign w_sge  = ~i_s;

  // Pick the cell matching the op code; reserved codes flag an error.
  always_comb begin
    w_bit = 1'b0;
    o_err = 1'b0;
    case (i_op)
      OPW'(OP_SLT):  w_bit = w_slt;
      OPW'(OP_SEQ):  w_bit = w_seq;
      OPW'(OP_SNE):  w_bit = w_sne;
      OPW'(OP_SGT):  w_bit = w_sgt;
      OPW'(OP_SLTE): w_bit = w_slte;
      OPW'(OP_SGE):  w_bit = w_sge;
      default:       o_err = 1'b1;
    endcase
  end

  assign o_result = {{(WIDTH-1){1'b0}}, w_bit};

endmodule

// File: rtl/set_op_sequencer.sv
// Set-condition op sequencer: round-robin arbitration of two requesters onto
// the shared adder/subtractor, one subtract a-b per op, and a 0/1 result
// returned over a valid/ready response port.
module set_op_sequencer
  import set_op_sequencer_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int OPW   = 3
) (
  input logic               clk,
  input logic               rst,
  set_op_sequencer_if.slave bus
);

  logic [1:0]       r_state;
  logic             r_rr_last;   // index of the last winner; 1 after reset so req0 goes first
  logic [OPW-1:0]   r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_id;
  logic [WIDTH-1:0] r_data;
  logic             r_err;

  logic             w_gnt0;
  logic             w_gnt1;
  logic             w_idle;
  logic             w_s;
  logic             w_z;
  logic [WIDTH-1:0] w_result;
  logic             w_err;
  logic             w_unused_res;

  assign w_s          = bus.sub_result[WIDTH-1];
  assign w_z          = bus.sub_zf;
  assign w_unused_res = ^bus.sub_result[WIDTH-2:0];

  // Round-robin grant: a lone requester wins, on a tie the one not served last wins.
  always_comb begin
    w_gnt0 = bus.req0_valid & (~bus.req1_valid | r_rr_last);
    w_gnt1 = bus.req1_valid & (~bus.req0_valid | ~r_rr_last);
  end

  // Ready only in IDLE and never while reset is applied.
  assign w_idle         = (r_state == ST_IDLE) & ~rst;
  assign bus.req0_ready = w_idle & w_gnt0;
  assign bus.req1_ready = w_idle & w_gnt1;

  assign bus.sub_req  = (r_state == ST_ISSUE);
  assign bus.sub_mode = (r_state == ST_ISSUE);
  assign bus.sub_a    = r_a;
  assign bus.sub_b    = r_b;

  assign bus.rsp_valid = (r_state == ST_RESP);
  assign bus.rsp_id    = r_id;
  assign bus.rsp_data  = r_data;
  assign bus.rsp_err   = r_err;

  set_result_sel #(
    .WIDTH (WIDTH),
    .OPW   (OPW)
  ) u_sel (
    .i_op     (r_op),
    .i_s      (w_s),
    .i_z      (w_z),
    .o_result (w_result),
    .o_err    (w_err)
  );

  // FSM, arbitration pointer, operand latches and response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_rr_last <= 1'b1;
      r_op      <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_id      <= 1'b0;
      r_data    <= '0;
      r_err     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_gnt0 | w_gnt1) begin
            r_state   <= ST_ISSUE;
            r_rr_last <= w_gnt1;
            r_id      <= w_gnt1;
            r_op      <= w_gnt1 ? bus.req1_op : bus.req0_op;
            r_a       <= w_gnt1 ? bus.req1_a  : bus.req0_a;
            r_b       <= w_gnt1 ? bus.req1_b  : bus.req0_b;
          end
        end
        ST_ISSUE: begin
          r_state <= ST_CAPT;
        end
        ST_CAPT: begin
          r_data  <= w_result;
          r_err   <= w_err;
          r_state <= ST_RESP;
        end
        ST_RESP: begin
          if (bus.rsp_ready) begin
            r_state <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule
